// File: rtl/addr_bus_unit_pkg.sv
// Shared definitions for the address-bus output unit: FSM states, pin-source
// encodings and the default bus widths used by the core's ADL/ADH buses.
package addr_bus_unit_pkg;

  localparam int AB_AW = 16;
  localparam int AB_LW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RESTORE = 2'd2
  } ab_state_e;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DMA = 1'b1
  } ab_src_e;

endpackage

// File: rtl/addr_bus_unit_if.sv
// Bus bundle between the core (ADL/ADH, load/increment strobes), the DMA
// channel and the address-bus unit that drives the pins.
interface addr_bus_unit_if
  import addr_bus_unit_pkg::*;
#(
  parameter int AW = AB_AW,
  parameter int LW = AB_LW
);

  logic [LW-1:0]    adl;
  logic [AW-LW-1:0] adh;
  logic             adl_abl;
  logic             adh_abh;
  logic             ab_inc;
  logic             dma_req;
  logic [AW-1:0]    dma_addr;
  logic             dma_ack;
  logic [AW-1:0]    ab_out;
  logic             ab_src;

  modport master (
    output adl, adh, adl_abl, adh_abh, ab_inc, dma_req, dma_addr,
    input  dma_ack, ab_out, ab_src
  );

  modport slave (
    input  adl, adh, adl_abl, adh_abh, ab_inc, dma_req, dma_addr,
    output dma_ack, ab_out, ab_src
  );

endinterface

// File: rtl/addr_bus_unit_ab_half_reg.sv
// One half of an address register: force-set, parallel load, or increment
// gated by a carry-in; exposes its next value and its carry-out.
module ab_half_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         res,
  input  logic         en,
  input  logic         set,
  input  logic [W-1:0] set_val,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         inc,
  input  logic         cin,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt,
  output logic         cout
);

  // Set beats load, load beats increment; cin gates the increment so the
  // high half only counts on a low-half wrap.
  always_comb begin
    nxt = q;
    if (set) begin
      nxt = set_val;
    end else if (load) begin
      nxt = d;
    end else if (inc && cin) begin
      nxt = q + W'(1);
    end
  end

  assign cout = inc & cin & (&q);

  always_ff @(posedge clk) begin
    if (res) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/addr_bus_unit.sv
// Address-bus output unit: CPU address register with a shadow copy that keeps
// tracking CPU updates while a DMA channel owns the pins.
module addr_bus_unit
  import addr_bus_unit_pkg::*;
#(
  parameter int            AW         = AB_AW,
  parameter int            LW         = AB_LW,
  parameter int            CARRY_PROP = 0,
  parameter logic [AW-1:0] RESET_VAL  = '0
) (
  input  logic            clk,
  input  logic            res,
  input  logic            phi1_en,
  addr_bus_unit_if.slave  bus
);

  localparam int HW = AW - LW;

  ab_state_e state, next_state;

  logic          cpu_inc;
  logic          ab_set;
  logic [AW-1:0] ab_set_val;

  logic [LW-1:0] ab_lo_q, ab_lo_nxt, sh_lo_q, sh_lo_nxt;
  logic [HW-1:0] ab_hi_q, ab_hi_nxt, sh_hi_q, sh_hi_nxt;
  logic          ab_lo_c, ab_hi_c, sh_lo_c, sh_hi_c;
  logic          ab_hi_cin, sh_hi_cin;
  logic          unused_bits;

  // Any explicit load cancels the increment for both halves.
  assign cpu_inc   = bus.ab_inc & ~(bus.adl_abl | bus.adh_abh);
  assign ab_hi_cin = (CARRY_PROP != 0) ? ab_lo_c : 1'b0;
  assign sh_hi_cin = (CARRY_PROP != 0) ? sh_lo_c : 1'b0;

  always_ff @(posedge clk) begin
    if (res) begin
      state <= ST_IDLE;
    end else if (phi1_en) begin
      state <= next_state;
    end
  end

  // The pins show the DMA address while owned; leaving OWN puts the shadow's
  // freshly updated value back on the pins in the same edge.
  always_comb begin
    next_state = state;
    ab_set     = 1'b0;
    ab_set_val = bus.dma_addr;
    case (state)
      ST_IDLE, ST_RESTORE: begin
        next_state = ST_IDLE;
        if (bus.dma_req) begin
          next_state = ST_OWN;
          ab_set     = 1'b1;
        end
      end
      ST_OWN: begin
        ab_set = 1'b1;
        if (!bus.dma_req) begin
          next_state = ST_RESTORE;
          ab_set_val = {sh_hi_nxt, sh_lo_nxt};
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  ab_half_reg #(.W(LW), .RST_VAL(RESET_VAL[LW-1:0])) u_ab_lo (
    .clk(clk), .res(res), .en(phi1_en),
    .set(ab_set), .set_val(ab_set_val[LW-1:0]),
    .load(bus.adl_abl), .d(bus.adl),
    .inc(cpu_inc), .cin(1'b1),
    .q(ab_lo_q), .nxt(ab_lo_nxt), .cout(ab_lo_c)
  );

  ab_half_reg #(.W(HW), .RST_VAL(RESET_VAL[AW-1:LW])) u_ab_hi (
    .clk(clk), .res(res), .en(phi1_en),
    .set(ab_set), .set_val(ab_set_val[AW-1:LW]),
    .load(bus.adh_abh), .d(bus.adh),
    .inc(cpu_inc), .cin(ab_hi_cin),
    .q(ab_hi_q), .nxt(ab_hi_nxt), .cout(ab_hi_c)
  );

  ab_half_reg #(.W(LW), .RST_VAL(RESET_VAL[LW-1:0])) u_sh_lo (
    .clk(clk), .res(res), .en(phi1_en),
    .set(1'b0), .set_val('0),
    .load(bus.adl_abl), .d(bus.adl),
    .inc(cpu_inc), .cin(1'b1),
    .q(sh_lo_q), .nxt(sh_lo_nxt), .cout(sh_lo_c)
  );

  ab_half_reg #(.W(HW), .RST_VAL(RESET_VAL[AW-1:LW])) u_sh_hi (
    .clk(clk), .res(res), .en(phi1_en),
    .set(1'b0), .set_val('0),
    .load(bus.adh_abh), .d(bus.adh),
    .inc(cpu_inc), .cin(sh_hi_cin),
    .q(sh_hi_q), .nxt(sh_hi_nxt), .cout(sh_hi_c)
  );

  assign bus.ab_out  = {ab_hi_q, ab_lo_q};
  assign bus.dma_ack = (state == ST_OWN);
  assign bus.ab_src  = (state == ST_OWN) ? SRC_DMA : SRC_CPU;

  assign unused_bits = ^{ab_lo_nxt, ab_hi_nxt, ab_hi_c, sh_hi_c, sh_lo_q, sh_hi_q};

endmodule

// File: tb/tb_addr_bus_unit.sv
// Directed bench for addr_bus_unit: two instances (no carry / carry into ABH)
// driven with identical stimulus and checked against hand-computed values.
module tb_addr_bus_unit;

  logic        clk = 1'b0;
  logic        res;
  logic        phi1_en;
  logic [7:0]  adl;
  logic [7:0]  adh;
  logic        adl_abl;
  logic        adh_abh;
  logic        ab_inc;
  logic        dma_req;
  logic [15:0] dma_addr;

  int checks = 0;
  int errors = 0;

  addr_bus_unit_if #(.AW(16), .LW(8)) if0 ();
  addr_bus_unit_if #(.AW(16), .LW(8)) if1 ();

  assign if0.adl = adl;           assign if1.adl = adl;
  assign if0.adh = adh;           assign if1.adh = adh;
  assign if0.adl_abl = adl_abl;   assign if1.adl_abl = adl_abl;
  assign if0.adh_abh = adh_abh;   assign if1.adh_abh = adh_abh;
  assign if0.ab_inc = ab_inc;     assign if1.ab_inc = ab_inc;
  assign if0.dma_req = dma_req;   assign if1.dma_req = dma_req;
  assign if0.dma_addr = dma_addr; assign if1.dma_addr = dma_addr;

  addr_bus_unit #(.AW(16), .LW(8), .CARRY_PROP(0), .RESET_VAL(16'h0000)) u_dut0 (
    .clk(clk), .res(res), .phi1_en(phi1_en), .bus(if0.slave)
  );

  addr_bus_unit #(.AW(16), .LW(8), .CARRY_PROP(1), .RESET_VAL(16'h0000)) u_dut1 (
    .clk(clk), .res(res), .phi1_en(phi1_en), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic checkBoth(input string tag, input logic [15:0] ab0, input logic [15:0] ab1,
                           input logic ack, input logic src);
    checkOutput({tag, " ab0"}, 32'(if0.ab_out), 32'(ab0));
    checkOutput({tag, " ab1"}, 32'(if1.ab_out), 32'(ab1));
    checkOutput({tag, " ack0"}, 32'(if0.dma_ack), 32'(ack));
    checkOutput({tag, " ack1"}, 32'(if1.dma_ack), 32'(ack));
    checkOutput({tag, " src0"}, 32'(if0.ab_src), 32'(src));
    checkOutput({tag, " src1"}, 32'(if1.ab_src), 32'(src));
  endtask

  task automatic clearControls();
    adl_abl = 1'b0;
    adh_abh = 1'b0;
    ab_inc  = 1'b0;
    dma_req = 1'b0;
  endtask

  // One clock edge, then settle before sampling outputs.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    res = 1'b1; phi1_en = 1'b0; adl = 8'h00; adh = 8'h00; dma_addr = 16'h0000;
    clearControls();
    applyStimulus();
    checkBoth("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);

    res = 1'b0; phi1_en = 1'b1;
    applyStimulus();
    checkBoth("idle", 16'h0000, 16'h0000, 1'b0, 1'b0);

    phi1_en = 1'b0; adl = 8'h34; adh = 8'h12; adl_abl = 1'b1; adh_abh = 1'b1; ab_inc = 1'b1;
    applyStimulus();
    checkBoth("hold_phi0", 16'h0000, 16'h0000, 1'b0, 1'b0);

    phi1_en = 1'b1;
    applyStimulus();
    checkBoth("load_both", 16'h1234, 16'h1234, 1'b0, 1'b0);

    clearControls(); adl = 8'hFF; adl_abl = 1'b1;
    applyStimulus();
    checkBoth("load_lo", 16'h12FF, 16'h12FF, 1'b0, 1'b0);

    clearControls(); ab_inc = 1'b1;
    applyStimulus();
    checkBoth("inc_12ff", 16'h1200, 16'h1300, 1'b0, 1'b0);

    phi1_en = 1'b0;
    applyStimulus();
    checkBoth("inc_hold", 16'h1200, 16'h1300, 1'b0, 1'b0);

    phi1_en = 1'b1; clearControls(); adl = 8'hFF; adh = 8'hFF; adl_abl = 1'b1; adh_abh = 1'b1;
    applyStimulus();
    checkBoth("load_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

    clearControls(); ab_inc = 1'b1;
    applyStimulus();
    checkBoth("inc_ffff", 16'hFF00, 16'h0000, 1'b0, 1'b0);

    clearControls(); adl = 8'h00; adh = 8'h80; adl_abl = 1'b1; adh_abh = 1'b1;
    applyStimulus();
    checkBoth("load_8000", 16'h8000, 16'h8000, 1'b0, 1'b0);

    // DMA takeover while the CPU keeps updating the shadow.
    clearControls(); dma_req = 1'b1; dma_addr = 16'h4014;
    applyStimulus();
    checkBoth("dma_take", 16'h4014, 16'h4014, 1'b1, 1'b1);

    adl = 8'h55; adl_abl = 1'b1;
    applyStimulus();
    checkBoth("dma_own_ld", 16'h4014, 16'h4014, 1'b1, 1'b1);

    adl_abl = 1'b0; ab_inc = 1'b1; dma_addr = 16'h4015;
    applyStimulus();
    checkBoth("dma_own_inc", 16'h4015, 16'h4015, 1'b1, 1'b1);

    clearControls();
    applyStimulus();
    checkBoth("dma_restore", 16'h8056, 16'h8056, 1'b0, 1'b0);

    applyStimulus();
    checkBoth("dma_idle", 16'h8056, 16'h8056, 1'b0, 1'b0);

    // Re-request straight out of RESTORE.
    dma_req = 1'b1; dma_addr = 16'h2000;
    applyStimulus();
    checkBoth("own2", 16'h2000, 16'h2000, 1'b1, 1'b1);

    dma_req = 1'b0;
    applyStimulus();
    checkBoth("restore2", 16'h8056, 16'h8056, 1'b0, 1'b0);

    dma_req = 1'b1; dma_addr = 16'h2001;
    applyStimulus();
    checkBoth("reown", 16'h2001, 16'h2001, 1'b1, 1'b1);

    dma_req = 1'b0;
    applyStimulus();
    checkBoth("restore3", 16'h8056, 16'h8056, 1'b0, 1'b0);

    // Reset in the middle of a DMA ownership.
    dma_req = 1'b1; dma_addr = 16'h1111;
    applyStimulus();
    checkBoth("own_pre_res", 16'h1111, 16'h1111, 1'b1, 1'b1);

    res = 1'b1;
    applyStimulus();
    checkBoth("res_in_own", 16'h0000, 16'h0000, 1'b0, 1'b0);

    res = 1'b0; dma_req = 1'b0;
    applyStimulus();
    checkBoth("after_res", 16'h0000, 16'h0000, 1'b0, 1'b0);

    // A request seen only while PHI1_EN is low must be ignored.
    phi1_en = 1'b0; dma_req = 1'b1; dma_addr = 16'h3333;
    applyStimulus();
    checkBoth("req_phi0", 16'h0000, 16'h0000, 1'b0, 1'b0);

    phi1_en = 1'b1; dma_req = 1'b0;
    applyStimulus();
    checkBoth("req_gone", 16'h0000, 16'h0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addr_bus_unit.md
Name: addr_bus_unit

Overview:
- Parametrised address-bus output unit. Holds the full address register (ABL low half, ABH high half) and drives the address pins.
- Loads each half from the internal ADL/ADH buses under separate enables. Adds a low-half increment with optional carry into ABH.
- Adds a DMA takeover channel that borrows the bus and restores the CPU address afterwards.
- Sits between the core's internal buses and the external address pins. Updates only on PHI1-phase cycles, marked by PHI1_EN.

Parameters:
- AW, 16, total address width.
- LW, 8, ABL width; ABH width is AW-LW. Requires 1 <= LW < AW.
- CARRY_PROP, 0, 0: increment wraps within the page and ABH is unchanged (6502 style); 1: the low-half carry increments ABH.
- RESET_VAL, 0, AB register and shadow value after reset.

Ports:
- CLK  in  1  the only clock; all state updates on its rising edge.
- RES  in  1  synchronous reset, active-high.
- PHI1_EN  in  1  PHI1 phase strobe; state changes only on edges where this is 1.
- ADL  in  LW  internal low address bus.
- ADH  in  AW-LW  internal high address bus.
- ADL_ABL  in  1  load ABL from ADL.
- ADH_ABH  in  1  load ABH from ADH.
- AB_INC  in  1  increment ABL.
- DMA_REQ  in  1  DMA requests the bus (level).
- DMA_ADDR  in  AW  DMA address.
- DMA_ACK  out  1  DMA owns the bus.
- AB_OUT  out  AW  registered address pins, {ABH, ABL}.
- AB_SRC  out  1  0 = CPU address on pins, 1 = DMA address on pins.

Behaviour:
- Clock and reset are fixed: one clock, CLK; reset RES is synchronous and active-high.
- Reset: RES=1 at an edge, regardless of PHI1_EN:
  - AB register and shadow register = RESET_VAL.
  - DMA_ACK=0, AB_SRC=0, FSM=IDLE.
  - RES has priority over every other input.
  - RES mid-DMA aborts the DMA immediately; no restore step is performed.
- PHI1_EN=0 at an edge: all registers and the FSM hold.
- CPU update function F(reg), used for AB in IDLE and for the shadow in OWN/RESTORE:
  - ADL_ABL=1: low half := ADL.
  - ADH_ABH=1: high half := ADH.
  - Each half's enable is independent.
  - If either load enable is 1, AB_INC is ignored for both halves.
  - Else, if AB_INC=1: low := low+1 mod 2^LW.
    - CARRY_PROP=1 and the low half was all-ones: high := high+1 mod 2^(AW-LW), so the full address wraps to 0 from all-ones.
    - CARRY_PROP=0: high unchanged.
- FSM (advances only on PHI1_EN edges):
  - IDLE:
    - AB := F(AB); shadow := F(AB).
    - If DMA_REQ=1, go to OWN, AB := DMA_ADDR, DMA_ACK=1, AB_SRC=1.
    - The CPU update in that same edge is applied to the shadow only.
  - OWN:
    - AB := DMA_ADDR on every PHI1_EN edge; shadow := F(shadow), so CPU loads are not lost.
    - If DMA_REQ=0, go to RESTORE and AB := F(shadow).
  - RESTORE:
    - Lasts one PHI1_EN edge. DMA_ACK is 0 in this state; AB_SRC=0.
    - AB shows the restored CPU address.
    - Then go to IDLE, or back to OWN if DMA_REQ=1 again (same rules as IDLE).
- Latency:
  - AB_OUT reflects inputs one PHI1_EN edge after they are sampled.
  - DMA_ACK rises on the same edge that DMA_ADDR first reaches AB_OUT.
- DMA_REQ pulses shorter than one PHI1_EN period are ignored; DMA_REQ is sampled only when PHI1_EN=1.

Decomposition:
- Shared package: FSM state encoding (IDLE/OWN/RESTORE); AB_SRC encodings; default AW/LW constants shared with the core's ADL/ADH bus definitions.
- One sub-module, ab_half_reg: parametrised-width register with load, increment, carry-in and carry-out.
  - Instantiated for ABL and ABH in both the AB and shadow registers.
  - ABL carry-out feeds ABH carry-in when CARRY_PROP=1.

Test Plan:
- Reset, then PHI1_EN pulses with no enables -> AB_OUT=0x0000, DMA_ACK=0, AB_SRC=0; holds on all edges with PHI1_EN=0.
- ADL=0x34 with ADL_ABL, ADH=0x12 with ADH_ABH on the same PHI1_EN edge -> AB_OUT=0x1234; AB_INC asserted together with the loads has no effect.
- AB=0x12FF, AB_INC:
  - CARRY_PROP=0 -> 0x1200.
  - CARRY_PROP=1 -> 0x1300.
  - AB=0xFFFF, CARRY_PROP=1 -> 0x0000.
- AB=0x8000, DMA_REQ=1, DMA_ADDR=0x4014 -> next PHI1_EN edge: AB_OUT=0x4014, DMA_ACK=1, AB_SRC=1.
  - During OWN, ADL=0x55 with ADL_ABL.
  - Drop DMA_REQ -> AB_OUT=0x8055, DMA_ACK=0, then IDLE.
- RES asserted during OWN -> next edge: AB_OUT=RESET_VAL, DMA_ACK=0, FSM=IDLE, no restore cycle.
- DMA_REQ high only on an edge with PHI1_EN=0 -> no state change, DMA_ACK stays 0.
